// File: rtl/cpu_run_ctrl_if.sv
// Board-side run-control signal bundle between the clock wrapper and cpu_run_ctrl.
// The master drives the switch/button/halt inputs; the slave returns enable, state, tick and count.
interface cpu_run_ctrl_if;
    logic        run_sw;
    logic        step_btn;
    logic        halt_req;
    logic        cpu_en;
    logic [1:0]  run_state;
    logic        scan_tick;
    logic [31:0] cycle_cnt;

    modport master (
        output run_sw, step_btn, halt_req,
        input  cpu_en, run_state, scan_tick, cycle_cnt
    );

    modport slave (
        input  run_sw, step_btn, halt_req,
        output cpu_en, run_state, scan_tick, cycle_cnt
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// CPU run control in the PLL clock domain: synchronised run switch, debounced single-step,
// halt-to-done FSM, Moore clock-enable, saturating enabled-cycle counter and free-running scan tick.
module cpu_run_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned TICK_DIV        = 23000
) (
    input logic          clk_in,
    input logic          rst_n,
    cpu_run_ctrl_if.slave bus
);
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TK_W = $clog2(TICK_DIV);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } state_e;

    logic [1:0]      run_sync_q, run_sync_d;
    logic [1:0]      btn_sync_q, btn_sync_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            btn_db_q, btn_db_d;
    logic            btn_db_dly_q, btn_db_dly_d;
    logic            step_pulse_q, step_pulse_d;
    state_e          state_q, state_d;
    logic [TK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic            scan_tick_q, scan_tick_d;
    logic [31:0]     cycle_cnt_q, cycle_cnt_d;
    logic            run_s, btn_s, cpu_en;

    assign run_s  = run_sync_q[1];
    assign btn_s  = btn_sync_q[1];
    assign cpu_en = (state_q == RUN) || (state_q == STEP);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin : sync_debounce
        run_sync_d   = {run_sync_q[0], bus.run_sw};
        btn_sync_d   = {btn_sync_q[0], bus.step_btn};
        db_cnt_d     = '0;
        btn_db_d     = btn_db_q;
        btn_db_dly_d = btn_db_q;
        step_pulse_d = btn_db_q & ~btn_db_dly_q;
        if (btn_s != btn_db_q) begin
            if (db_cnt_q == DB_LAST) btn_db_d = btn_s;
            else                     db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    // Run beats a coincident step in IDLE; DONE is left only through reset.
    always_comb begin : next_state
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (run_s)             state_d = RUN;
                else if (step_pulse_q) state_d = STEP;
            end
            RUN: begin
                if (bus.halt_req)      state_d = DONE;
                else if (!run_s)       state_d = IDLE;
            end
            STEP:    state_d = bus.halt_req ? DONE : IDLE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : counters
        tick_cnt_d  = (tick_cnt_q == TK_LAST) ? '0 : tick_cnt_q + 1'b1;
        scan_tick_d = (tick_cnt_q == TK_LAST);
        cycle_cnt_d = cycle_cnt_q;
        if (cpu_en && (cycle_cnt_q != 32'hFFFF_FFFF)) cycle_cnt_d = cycle_cnt_q + 32'd1;
    end

    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            run_sync_q   <= '0;
            btn_sync_q   <= '0;
            db_cnt_q     <= '0;
            btn_db_q     <= 1'b0;
            btn_db_dly_q <= 1'b0;
            step_pulse_q <= 1'b0;
            state_q      <= IDLE;
            tick_cnt_q   <= '0;
            scan_tick_q  <= 1'b0;
            cycle_cnt_q  <= '0;
        end else begin
            run_sync_q   <= run_sync_d;
            btn_sync_q   <= btn_sync_d;
            db_cnt_q     <= db_cnt_d;
            btn_db_q     <= btn_db_d;
            btn_db_dly_q <= btn_db_dly_d;
            step_pulse_q <= step_pulse_d;
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            scan_tick_q  <= scan_tick_d;
            cycle_cnt_q  <= cycle_cnt_d;
        end
    end

    assign bus.cpu_en    = cpu_en;
    assign bus.run_state = state_q;
    assign bus.scan_tick = scan_tick_q;
    assign bus.cycle_cnt = cycle_cnt_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: a cycle-level reference model pushes the expected
// outputs after every driven edge; an independent monitor pops and compares them.
module tb_cpu_run_ctrl;
    localparam int DB = 4;
    localparam int TD = 5;

    typedef enum int {S_IDLE = 0, S_RUN = 1, S_STEP = 2, S_DONE = 3} mstate_e;
    typedef struct packed {
        logic        en;
        logic [1:0]  st;
        logic        tick;
        logic [31:0] cnt;
    } obs_t;

    logic clk_in = 1'b0;
    logic rst_n;
    cpu_run_ctrl_if bus ();

    cpu_run_ctrl #(.DEBOUNCE_CYCLES(DB), .TICK_DIV(TD)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Reference model: raw inputs seen through two-edge delay lines, debounce as a run length
    // of disagreeing samples, and the FSM expressed directly in terms of the run/step/halt rules.
    bit      m_run_hist[2];
    bit      m_btn_hist[2];
    bit      m_db, m_db_prev, m_pulse;
    int      m_diff_len;
    mstate_e m_state;
    longint  m_cnt;
    int      m_edges;
    bit      m_tick;

    task automatic model_reset();
        m_run_hist = '{default: 1'b0};
        m_btn_hist = '{default: 1'b0};
        m_db = 1'b0; m_db_prev = 1'b0; m_pulse = 1'b0;
        m_diff_len = 0; m_state = S_IDLE; m_cnt = 0; m_edges = 0; m_tick = 1'b0;
    endtask

    task automatic model_edge(input bit run, input bit btn, input bit halt, input bit rst);
        bit      run_s, btn_s, en_now, db_next;
        int      len_next;
        mstate_e st_next;
        obs_t    e;
        run_s = m_run_hist[1];
        btn_s = m_btn_hist[1];
        if (!rst) begin
            model_reset();
        end else begin
            en_now   = (m_state == S_RUN) || (m_state == S_STEP);
            db_next  = m_db;
            len_next = 0;
            if (btn_s != m_db) begin
                len_next = m_diff_len + 1;
                if (len_next == DB) begin
                    db_next  = btn_s;
                    len_next = 0;
                end
            end
            st_next = m_state;
            case (m_state)
                S_IDLE: if (run_s) st_next = S_RUN; else if (m_pulse) st_next = S_STEP;
                S_RUN:  if (halt) st_next = S_DONE; else if (!run_s) st_next = S_IDLE;
                S_STEP: st_next = halt ? S_DONE : S_IDLE;
                default: st_next = S_DONE;
            endcase
            if (en_now && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
            m_pulse    = m_db && !m_db_prev;
            m_db_prev  = m_db;
            m_db       = db_next;
            m_diff_len = len_next;
            m_state    = st_next;
            m_edges    = m_edges + 1;
            m_tick     = (m_edges % TD) == 0;
            m_run_hist[1] = m_run_hist[0]; m_run_hist[0] = run;
            m_btn_hist[1] = m_btn_hist[0]; m_btn_hist[0] = btn;
        end
        e.en   = (m_state == S_RUN) || (m_state == S_STEP);
        e.st   = 2'(m_state);
        e.tick = m_tick;
        e.cnt  = 32'(m_cnt);
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit run, input bit btn, input bit halt, input bit rst);
        @(negedge clk_in);
        bus.run_sw = run; bus.step_btn = btn; bus.halt_req = halt; rst_n = rst;
        model_edge(run, btn, halt, rst);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic check(input string name, input obs_t got, input obs_t want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got en=%b st=%0d tick=%b cnt=%h, want en=%b st=%0d tick=%b cnt=%h",
                     name, got.en, got.st, got.tick, got.cnt, want.en, want.st, want.tick, want.cnt);
        end
    endtask

    // Monitor: the DUT presents a fresh output set after every edge; compare it just past the edge.
    initial begin : monitor
        obs_t got, want;
        forever begin
            @(posedge clk_in);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got  = {bus.cpu_en, bus.run_state, bus.scan_tick, bus.cycle_cnt};
                check($sformatf("cyc%0d", cyc), got, want);
            end
        end
    end

    initial begin : stimulus
        int steps;
        bit run, btn, halt, rst;
        int len;
        rst_n = 1'b0; bus.run_sw = 1'b0; bus.step_btn = 1'b0; bus.halt_req = 1'b0;
        model_reset();

        // Reset, then idle: only the scan tick moves.
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
        idle(20);

        // Run switch held for 10 edges.
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0, 1'b1);
        idle(6);

        // Reset, then two clean step presses with releases.
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0, 1'b1);
            idle(10);
        end

        // Bounce shorter than the debounce window.
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) drive(1'b0, ((i / 2) % 2) == 0, 1'b0, 1'b1);
        idle(10);

        // Halt in RUN, then everything ignored until reset.
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) drive(i % 5 < 2, i > 4 && i < 15, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        idle(5);

        // Reset landing while the FSM sits in STEP.
        steps = 0;
        while (m_state != S_STEP && steps < 30) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1);
            steps++;
        end
        if (m_state != S_STEP) begin
            n_cmp++; n_bad++;
            $display("FAIL step_reach: got no STEP within %0d cycles, want STEP", steps);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(10);

        // Counter preloaded near its ceiling, long run into saturation, reset while running.
        @(negedge clk_in);
        force dut.cycle_cnt_q = 32'hFFFF_FFF0;
        bus.run_sw = 1'b0; bus.step_btn = 1'b0; bus.halt_req = 1'b0; rst_n = 1'b1;
        m_cnt = 64'hFFFF_FFF0;
        model_edge(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk_in);
        release dut.cycle_cnt_q;
        bus.run_sw = 1'b1;
        model_edge(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 30; i++) drive(1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(5);

        // Randomised segments of held inputs with occasional halt pulses and resets.
        for (int s = 0; s < 400; s++) begin
            len  = $urandom_range(12, 1);
            run  = $urandom_range(2, 0) == 0;
            btn  = $urandom_range(1, 0) == 1;
            for (int i = 0; i < len; i++) begin
                halt = $urandom_range(39, 0) == 0;
                rst  = $urandom_range(59, 0) != 0;
                drive(run, btn, halt, rst);
            end
        end
        idle(3);

        @(posedge clk_in);
        #2;
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
